// File: rtl/ma_stage_param.sv
// Memory-access stage: pass/load/store on a local data memory with a valid/ack
// handshake, post-reset hardware clear and sticky out-of-range flag.
// Optional feature macro: MA_FETCH_ADD_EN (OP=11 becomes fetch-add instead of load).
module ma_stage_param #(
  parameter int unsigned PACKET_W = 40,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                CP,
  input  logic                MR,
  input  logic                Send_in,
  output logic                Ack_out,
  input  logic [1:0]          OP,
  input  logic [DATA_W-1:0]   WRITE_DATA,
  input  logic [PACKET_W-1:0] PACKET_IN,
  output logic                Send_out,
  input  logic                Ack_in,
  output logic [PACKET_W-1:0] PACKET_OUT,
  output logic                BUSY,
  output logic                ERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_FADD  = 2'b11;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic                r_send_out;
  logic                w_send_out_nxt;
  logic [PACKET_W-1:0] r_packet_out;
  logic [PACKET_W-1:0] w_packet_out_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_addr;
  logic [IDX_W-1:0]    w_idx;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_accept;
  logic                w_mem_we;
  logic [IDX_W-1:0]    w_mem_idx;
  logic [DATA_W-1:0]   w_mem_wd;

  assign w_addr     = PACKET_IN[ADDR_W-1:0];
  assign w_idx      = IDX_W'(w_addr);
  assign w_in_range = (32'(w_addr) < DEPTH);
  // Out-of-range reads must never touch the array; they load zero.
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

  assign Ack_out    = (r_state == S_RUN) && (!r_send_out || Ack_in);
  assign w_accept   = Send_in && Ack_out;

  assign Send_out   = r_send_out;
  assign PACKET_OUT = r_packet_out;
  assign ERR        = r_err;
  assign BUSY       = (r_state == S_CLEAR);

  // Next-state, output-register and memory-write decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_send_out_nxt   = r_send_out;
    w_packet_out_nxt = r_packet_out;
    w_err_nxt        = r_err;
    w_mem_we         = 1'b0;
    w_mem_idx        = w_idx;
    w_mem_wd         = WRITE_DATA;

    case (r_state)
      S_CLEAR: begin
        w_mem_we  = 1'b1;
        w_mem_idx = r_ptr;
        w_mem_wd  = '0;
        if (r_ptr == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + IDX_W'(1);
        end
      end
      default: begin
        if (w_accept) begin
          w_send_out_nxt   = 1'b1;
          w_packet_out_nxt = PACKET_IN;
          if ((OP != OP_PASS) && !w_in_range) begin
            w_err_nxt = 1'b1;
          end
          case (OP)
            OP_LOAD: w_packet_out_nxt[DATA_W-1:0] = w_rd_data;
            OP_STORE: w_mem_we = w_in_range;
`ifdef MA_FETCH_ADD_EN
            OP_FADD: begin
              w_packet_out_nxt[DATA_W-1:0] = w_rd_data;
              w_mem_we = w_in_range;
              w_mem_wd = w_rd_data + WRITE_DATA;
            end
`else
            OP_FADD: w_packet_out_nxt[DATA_W-1:0] = w_rd_data;
`endif
            default: ;
          endcase
        end else if (Ack_in) begin
          w_send_out_nxt = 1'b0;
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_state      <= S_CLEAR;
      r_ptr        <= '0;
      r_send_out   <= 1'b0;
      r_packet_out <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_send_out   <= w_send_out_nxt;
      r_packet_out <= w_packet_out_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Data memory; contents are initialised by the CLEAR sweep, not by reset.
  always_ff @(posedge CP) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wd;
    end
  end

endmodule

// File: doc/ma_stage_param.md
# ma_stage_param

Parametrised memory-access stage for the data-driven pipeline: accepts one packet per transfer, performs pass/load/store (and optionally fetch-add) on a local data memory addressed by the packet's low field, and emits the packet with loaded data merged in. It sits between the execute stage and the matching/output stages. It replaces the fixed 40/16/1024 stage with configurable width and depth, a clocked valid/ack handshake with backpressure, a hardware post-reset memory clear, and out-of-range address detection.

## Interface
- PACKET_W, 40, packet width
- DATA_W, 16, memory word width; merge field is PACKET[DATA_W-1:0]
- ADDR_W, 10, address width; address = PACKET_IN[ADDR_W-1:0]; ADDR_W <= DATA_W
- DEPTH, 1024, memory words, 1 <= DEPTH <= 2^ADDR_W, need not be a power of two

- CP  in  1  clock, rising edge
- MR  in  1  reset, asynchronous, active-high
- Send_in  in  1  upstream packet valid
- Ack_out  out  1  stage can accept this cycle
- OP  in  2  00 pass, 01 load, 10 store, 11 fetch-add; sampled with PACKET_IN
- WRITE_DATA  in  DATA_W  store / addend value
- PACKET_IN  in  PACKET_W  incoming packet
- Send_out  out  1  output packet valid
- Ack_in  in  1  downstream accepts
- PACKET_OUT  out  PACKET_W  output packet
- BUSY  out  1  memory clear in progress
- ERR  out  1  sticky: out-of-range access occurred

## Operation
- States: CLEAR, RUN. MR forces CLEAR, clear pointer 0, output register empty, ERR 0.
- CLEAR: each CP edge writes 0 to mem[ptr], ptr++; edge writing DEPTH-1 moves to RUN. BUSY=1, Ack_out=0.
- RUN: Ack_out = !Send_out || Ack_in. Accept = Send_in && Ack_out at CP edge.
- On accept (address a, in range a < DEPTH):
  - pass: PACKET_OUT <= PACKET_IN.
  - load: PACKET_OUT <= {PACKET_IN[PACKET_W-1:DATA_W], mem[a]}.
  - store: mem[a] <= WRITE_DATA; PACKET_OUT <= PACKET_IN unchanged.
  - fetch-add: out field = old mem[a]; mem[a] <= (mem[a] + WRITE_DATA) mod 2^DATA_W.
- Out of range (a >= DEPTH, load/store/fetch-add only): no memory write; loaded field = 0; ERR <= 1 until MR. Pass ignores the address.
- Memory read and write at the accept edge use pre-edge contents; back-to-back ops to one address see all prior writes (no hazard, no bypass).
- No accept: PACKET_OUT, Send_out and memory hold; Send_out clears on edge with Ack_in=1 and no accept.

## Timing
- Reset values: Send_out 0, Ack_out 0, PACKET_OUT 0, BUSY 1, ERR 0.
- Clear: Ack_out first 1 after exactly DEPTH CP edges following MR deassert.
- Latency 1: packet accepted at edge k is on PACKET_OUT with Send_out=1 after edge k.
- Throughput one packet/cycle with Ack_in held 1; simultaneous drain and accept allowed.
- Ack_in=0 with Send_out=1 stalls: Ack_out=0, output stable, no memory side effects.
- MR mid-clear or mid-stream: in-flight packet dropped, clear restarts at 0.

## Configuration
- MA_FETCH_ADD_EN defined: OP=11 is fetch-add as above.
- Undefined: OP=11 behaves exactly as load (no write); adder absent.

## Test plan
- DEPTH=16: release MR -> BUSY=1, Ack_out=0 for 16 edges, then Ack_out=1; load any address returns 0x0000.
- Store 0x1234 @5, then load @5 with upper field 0xABCDEF -> PACKET_OUT = 0xABCDEF1234, latency 1.
- Ack_in=0 for 3 cycles with Send_out=1 -> PACKET_OUT stable, Ack_out=0, a stalled store is not written until accepted.
- MA_FETCH_ADD_EN, mem[3]=0xFFFF, fetch-add 0x0002 twice -> outputs 0xFFFF then 0x0001; mem[3]=0x0003.
- DEPTH=12, store @13 then load @13 -> no write, loaded field 0, ERR=1 held until MR.
- MR asserted one cycle after accept -> Send_out=0, PACKET_OUT=0 immediately; full clear repeats.
